alu33_issue_ctrl: RTL and testbench

- Issue/writeback controller directly upstream and downstream of the alu33 execute stage.
- Accepts 16-bit instructions via valid/ready, decodes them, reads a 4-entry register file, drives the ALU control/operand inputs, and captures the combinational ALU result and flags.
- Writes the result back to the register file and presents it downstream via valid/ready.
- Three-state FSM; one instruction in flight.

---
 rtl/alu33_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_alu33_issue_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu33_issue_ctrl.sv
// alu33_issue_ctrl: issue/writeback controller wrapped around the alu33 execute
// stage. Accepts one instruction at a time and moves it through three states:
// IDLE (decode, register read), EXEC (ALU settles) and WB (result held for the
// downstream stage). The register file write and the flag update happen at the
// output handshake.
// Optional feature: define ALU33_DIV0_TRAP_EN to trap opcode 0100 (divide)
// with a zero second operand as an illegal instruction.
module alu33_issue_ctrl #(
    parameter int NREGS  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_inst,
    input  logic [15:0]       in_fp_a,
    input  logic [15:0]       in_fp_b,
    output logic [3:0]        alu_ctrl,
    output logic [3:0]        alu_op1,
    output logic [3:0]        alu_op2,
    output logic [15:0]       alu_fp_op1,
    output logic [15:0]       alu_fp_op2,
    output logic              alu_reset,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [15:0]       alu_fp_result,
    input  logic              alu_zero,
    input  logic              alu_negative,
    input  logic              alu_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [15:0]       out_fp_result,
    output logic [1:0]        out_rd,
    output logic              out_wen,
    output logic              out_branch,
    output logic              out_illegal,
    output logic [2:0]        flags,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_BRANCH = 4'd10;

    state_t            state;
    logic [DATA_W-1:0] regs [NREGS];
    logic [2:0]        flags_pend;

    // Instruction fields
    logic [3:0] dec_opcode;
    logic [1:0] dec_rd;
    logic [1:0] dec_rs1;
    logic [1:0] dec_rs2;
    logic [3:0] dec_imm;
    logic       dec_use_imm;
    logic [3:0] dec_op1;
    logic [3:0] dec_op2;
    logic       dec_illegal;
    logic       accept;
    logic       unused_reserved;

    assign dec_opcode      = in_inst[15:12];
    assign dec_rd          = in_inst[11:10];
    assign dec_rs1         = in_inst[9:8];
    assign dec_rs2         = in_inst[7:6];
    assign dec_imm         = in_inst[5:2];
    assign dec_use_imm     = in_inst[1];
    assign unused_reserved = in_inst[0];

    // Operands use only the low nibble of each 8-bit register
    assign dec_op1 = regs[dec_rs1][3:0];
    assign dec_op2 = dec_use_imm ? dec_imm : regs[dec_rs2][3:0];

`ifdef ALU33_DIV0_TRAP_EN
    assign dec_illegal = (dec_opcode > OP_BRANCH) ||
                         ((dec_opcode == OP_DIV) && (dec_op2 == 4'd0));
`else
    assign dec_illegal = (dec_opcode > OP_BRANCH);
`endif

    assign in_ready  = (state == IDLE) && !reset;
    assign out_valid = (state == WB);
    assign accept    = in_valid && in_ready;
    assign alu_reset = reset;

    // Issue / execute / writeback sequencing with all architectural state
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            flags         <= '0;
            flags_pend    <= '0;
            retired       <= '0;
            alu_ctrl      <= '0;
            alu_op1       <= '0;
            alu_op2       <= '0;
            alu_fp_op1    <= '0;
            alu_fp_op2    <= '0;
            out_result    <= '0;
            out_fp_result <= '0;
            out_rd        <= '0;
            out_wen       <= 1'b0;
            out_branch    <= 1'b0;
            out_illegal   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        out_rd <= dec_rd;
                        // Flags only change at a writeback handshake, so the
                        // zero flag sampled here is the one before this branch.
                        out_branch <= (dec_opcode == OP_BRANCH) && flags[0];
                        if (dec_illegal) begin
                            // Skip EXEC; ALU drive registers keep their values
                            out_illegal   <= 1'b1;
                            out_wen       <= 1'b0;
                            out_result    <= '0;
                            out_fp_result <= '0;
                            state         <= WB;
                        end else begin
                            alu_ctrl    <= dec_opcode;
                            alu_op1     <= dec_op1;
                            alu_op2     <= dec_op2;
                            alu_fp_op1  <= in_fp_a;
                            alu_fp_op2  <= in_fp_b;
                            out_illegal <= 1'b0;
                            out_wen     <= (dec_opcode != OP_BRANCH);
                            state       <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    out_result    <= alu_result;
                    out_fp_result <= alu_fp_result;
                    flags_pend    <= {alu_overflow, alu_negative, alu_zero};
                    state         <= WB;
                end
                WB: begin
                    if (out_ready) begin
                        // Branches and illegal instructions leave regs/flags alone
                        if (out_wen) begin
                            regs[out_rd] <= out_result;
                            flags        <= flags_pend;
                        end
                        retired <= retired + CNT_W'(1);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu33_issue_ctrl.sv
// Testbench for alu33_issue_ctrl. A behavioural stand-in for the alu33 execute
// stage answers the controller's ALU outputs combinationally. Stimulus issues
// directed and random instructions, predicting each retirement from an
// architectural model (register array, flags, retire count) and queuing it;
// an independent monitor compares every presented output against the queue.
module tb_alu33_issue_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_inst;
    logic [15:0]       in_fp_a;
    logic [15:0]       in_fp_b;
    logic [3:0]        alu_ctrl;
    logic [3:0]        alu_op1;
    logic [3:0]        alu_op2;
    logic [15:0]       alu_fp_op1;
    logic [15:0]       alu_fp_op2;
    logic              alu_reset;
    logic [DATA_W-1:0] alu_result;
    logic [15:0]       alu_fp_result;
    logic              alu_zero;
    logic              alu_negative;
    logic              alu_overflow;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_result;
    logic [15:0]       out_fp_result;
    logic [1:0]        out_rd;
    logic              out_wen;
    logic              out_branch;
    logic              out_illegal;
    logic [2:0]        flags;
    logic [CNT_W-1:0]  retired;

    always #5 clk = ~clk;

    alu33_issue_ctrl #(.NREGS(4), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_fp_a(in_fp_a), .in_fp_b(in_fp_b),
        .alu_ctrl(alu_ctrl), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_fp_op1(alu_fp_op1), .alu_fp_op2(alu_fp_op2), .alu_reset(alu_reset),
        .alu_result(alu_result), .alu_fp_result(alu_fp_result),
        .alu_zero(alu_zero), .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_fp_result(out_fp_result), .out_rd(out_rd),
        .out_wen(out_wen), .out_branch(out_branch), .out_illegal(out_illegal),
        .flags(flags), .retired(retired)
    );

    // Stand-in ALU: returns {overflow, negative, zero, fp_product, result}
    function automatic logic [26:0] alu_ref(input logic [3:0] op, input logic [3:0] a,
                                            input logic [3:0] b, input logic [15:0] fa,
                                            input logic [15:0] fb);
        logic [7:0]  r;
        logic [15:0] p;
        p = 16'h0000;
        case (op)
            4'd0:    r = 8'(a) + 8'(b);
            4'd1:    r = 8'(a) - 8'(b);
            4'd2:    begin p = fa * fb; r = p[7:0]; end
            4'd3:    r = {4'h0, a & b};
            4'd4:    r = (b == 4'd0) ? 8'hFF : {4'h0, a / b};
            4'd5:    r = {4'h0, a | b};
            4'd6:    r = {4'h0, a ^ b};
            4'd7:    r = 8'(a) << b[1:0];
            4'd8:    r = {4'h0, a >> b[1:0]};
            4'd9:    r = {4'h0, b};
            default: r = 8'(a) - 8'(b);
        endcase
        return {r[4], r[3], (r == 8'h00), p, r};
    endfunction

    logic [26:0] alu_v;
    always_comb begin
        alu_v = alu_ref(alu_ctrl, alu_op1, alu_op2, alu_fp_op1, alu_fp_op2);
    end
    assign alu_result    = alu_v[7:0];
    assign alu_fp_result = alu_v[23:8];
    assign alu_zero      = alu_v[24];
    assign alu_negative  = alu_v[25];
    assign alu_overflow  = alu_v[26];

    typedef struct {
        logic [7:0]  res;
        logic [15:0] fp;
        logic [1:0]  rd;
        logic        wen;
        logic        br;
        logic        ill;
        logic [2:0]  fl;
        logic [15:0] ret;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mregs [4];
    logic [2:0]  mflags;
    logic [15:0] mret;
    int          tests = 0;
    int          fails = 0;
    int          ncyc  = 0;
    bit          rdy_hold = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) ncyc <= ncyc + 1;

    // Downstream back-pressure, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        out_ready = rdy_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare every presented result against the queue head
    bit          seen = 1'b0;
    bit          post_chk = 1'b0;
    logic [2:0]  post_fl;
    logic [15:0] post_ret;
    always @(negedge clk) begin
        if (post_chk) begin
            chk("flags_after_wb", 32'(flags), 32'(post_fl));
            chk("retired_after_wb", 32'(retired), 32'(post_ret));
            chk("in_ready_after_wb", 32'(in_ready), 32'(!reset));
            post_chk = 1'b0;
        end
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(ncyc - q[0].acc), 32'(q[0].lat));
                    seen = 1'b1;
                end
                chk("out_result", 32'(out_result), 32'(q[0].res));
                chk("out_rd", 32'(out_rd), 32'(q[0].rd));
                chk("out_wen", 32'(out_wen), 32'(q[0].wen));
                chk("out_branch", 32'(out_branch), 32'(q[0].br));
                chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
                if (!q[0].ill) chk("out_fp_result", 32'(out_fp_result), 32'(q[0].fp));
                chk("in_ready_in_wb", 32'(in_ready), 32'd0);
                if (out_ready) begin
                    post_fl  = q[0].fl;
                    post_ret = q[0].ret;
                    post_chk = 1'b1;
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        mflags = 3'b000;
        mret   = 16'h0000;
    endtask

    // Issue one instruction (called on a falling edge); optional WB stall
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [3:0] imm, input logic use_imm,
                         input bit stall);
        exp_t        e;
        logic [3:0]  a, b;
        logic [26:0] v;
        logic [15:0] fa, fb;
        logic [2:0]  fl_before;
        logic [15:0] ret_before;
        int          waitc;
        waitc = 0;
        while (!in_ready && waitc < 60) begin
            @(negedge clk);
            waitc++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        if (!in_ready) return;
        fa = 16'($urandom);
        fb = 16'($urandom);
        a  = mregs[rs1][3:0];
        b  = use_imm ? imm : mregs[rs2][3:0];
        e.ill = (op >= 4'd11);
`ifdef ALU33_DIV0_TRAP_EN
        if (op == 4'd4 && b == 4'd0) e.ill = 1'b1;
`endif
        v          = alu_ref(op, a, b, fa, fb);
        fl_before  = mflags;
        ret_before = mret;
        e.rd  = rd;
        e.acc = ncyc;
        e.lat = e.ill ? 1 : 2;
        if (e.ill) begin
            e.res = 8'h00; e.fp = 16'h0000; e.wen = 1'b0; e.br = 1'b0;
        end else begin
            e.res = v[7:0];
            e.fp  = v[23:8];
            e.wen = (op != 4'd10);
            e.br  = (op == 4'd10) && mflags[0];
        end
        if (e.wen) begin
            mregs[rd] = e.res;
            mflags    = v[26:24];
        end
        mret  = mret + 16'd1;
        e.fl  = mflags;
        e.ret = mret;
        q.push_back(e);
        if (stall) rdy_hold = 1'b1;
        in_inst  = {op, rd, rs1, rs2, imm, use_imm, 1'($urandom)};
        in_fp_a  = fa;
        in_fp_b  = fb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_inst  = 16'($urandom);
        if (stall) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("stall_flags_held", 32'(flags), 32'(fl_before));
                chk("stall_retired_held", 32'(retired), 32'(ret_before));
                chk("stall_out_valid", 32'(out_valid), 32'd1);
            end
            rdy_hold = 1'b0;
        end
    endtask

    initial begin
        int w;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_inst  = 16'h0000;
        in_fp_a  = 16'h0000;
        in_fp_b  = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_reset", 32'(alu_reset), 32'd1);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_alu_reset", 32'(alu_reset), 32'd0);

        // Directed sequence
        issue(4'd9,  2'd1, 2'd0, 2'd0, 4'd5, 1'b1, 1'b0);  // reg1 = 5
        issue(4'd0,  2'd2, 2'd1, 2'd0, 4'd3, 1'b1, 1'b1);  // reg2 = 8, stalled WB
        issue(4'd13, 2'd3, 2'd2, 2'd1, 4'd7, 1'b0, 1'b0);  // illegal
        issue(4'd10, 2'd0, 2'd2, 2'd1, 4'd0, 1'b0, 1'b0);  // branch, zero clear
        issue(4'd0,  2'd3, 2'd2, 2'd0, 4'd0, 1'b1, 1'b0);  // read back reg2
        issue(4'd4,  2'd1, 2'd2, 2'd0, 4'd0, 1'b1, 1'b0);  // divide by zero
        issue(4'd0,  2'd0, 2'd1, 2'd0, 4'd0, 1'b1, 1'b0);  // read back reg1
        issue(4'd1,  2'd0, 2'd1, 2'd1, 4'd0, 1'b0, 1'b0);  // zero result
        issue(4'd10, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 1'b0);  // branch taken

        // Random phase
        for (int n = 0; n < 150; n++) begin
            logic [3:0] op;
            logic [3:0] imm;
            op  = 4'($urandom_range(0, 15));
            imm = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom);
            issue(op, 2'($urandom), 2'($urandom), 2'($urandom), imm, 1'($urandom),
                  ($urandom_range(0, 15) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset while an instruction is in EXEC
        issue(4'd9, 2'd2, 2'd0, 2'd0, 4'd9, 1'b1, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_retired", 32'(retired), 32'd0);
        chk("midrst_flags", 32'(flags), 32'd0);
        chk("midrst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("midrst_out_result", 32'(out_result), 32'd0);
        q.delete();
        model_reset();
        reset = 1'b0;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            issue(4'd0, 2'(r), 2'(r), 2'(r), 4'd0, 1'b0, 1'b0);  // cleared regs read 0
        end
        for (int n = 0; n < 30; n++) begin
            issue(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom),
                  4'($urandom), 1'($urandom), 1'b0);
        end

        w = 0;
        while (q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_queue", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
